bar_sram_responder: RTL
=======================

BAR_SRAM_RESPONDER -- requirements
Module: bar_sram_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4096: number of words in the bank.
REQ-003 SHALL have parameter BASE, default 32'h0000_0000: word address mapped to bank index 0.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port bar_write_en, input, 1: accelerator write strobe.
REQ-008 SHALL have port bar_data_in, input, WIDTH: accelerator write data.
REQ-009 SHALL have port bar_addr, input, 32: accelerator word address; sampled every cycle.
REQ-010 SHALL have port bar_data_out, output, WIDTH: registered read data for the accelerator.
REQ-011 SHALL have port acc_active, input, 1: accelerator owns the bank; high for the whole start..done window.
REQ-012 SHALL have port host_req, input, 1: host access request; held until granted.
REQ-013 SHALL have port host_we, input, 1: host write (1) or read (0).
REQ-014 SHALL have port host_addr, input, 32: host word address.
REQ-015 SHALL have port host_wdata, input, WIDTH: host write data.
REQ-016 SHALL have port host_gnt, output, 1: combinational grant; access takes effect on this edge.
REQ-017 SHALL have port host_rvalid, output, 1: registered one-cycle pulse marking valid host_rdata.
REQ-018 SHALL have port host_rdata, output, WIDTH: host read data; holds until the next host read.
REQ-019 SHALL have port err, output, 1: sticky out-of-range access flag.
REQ-020 SHALL have port err_clr, input, 1: clears err.
REQ-021 SHALL have port wr_count, output, 32: count of accepted in-range writes from either port.

Function
REQ-022 SHALL compute idx = addr - BASE (32-bit unsigned); an address is in range iff idx < DEPTH.
REQ-023 SHALL, when acc_active=1, serve only the accelerator port; host_gnt=0.
REQ-024 SHALL, when acc_active=0, assert host_gnt = host_req; accelerator writes are ignored and bar_data_out still tracks reads.
REQ-025 SHALL read mem[idx(bar_addr)] every cycle into bar_data_out; data appears 1 cycle after the address (latency 1).
REQ-026 SHALL perform a write to mem[idx] on the edge where bar_write_en=1 and acc_active=1, or where host_gnt=1 and host_we=1.
REQ-027 SHALL be read-first: a same-cycle read and write to one index returns the old word; the new word is visible on the following read.
REQ-028 SHALL, on a granted host read, load host_rdata with mem[idx(host_addr)] and pulse host_rvalid for exactly 1 cycle on the next cycle.
REQ-029 SHALL drop out-of-range writes (memory unchanged, wr_count unchanged) and set err.
REQ-030 SHALL return 0 for out-of-range reads and set err; accelerator reads set err only when acc_active=1.
REQ-031 SHALL give set priority over err_clr when both occur in one cycle.
REQ-032 SHALL increment wr_count by 1 per accepted write and saturate at 32'hFFFF_FFFF.
REQ-033 SHALL, when acc_active falls with host_req held, grant the host in the first cycle acc_active=0.
REQ-034 SHALL not initialise memory contents; contents are undefined until written.

Reset
REQ-035 SHALL, when rst=1, set bar_data_out=0, host_rvalid=0, host_rdata=0, err=0, wr_count=0, leave memory unchanged, and take no writes that cycle.
REQ-036 SHALL, on reset mid-operation, discard any pending host_rvalid; the host re-requests after reset.

Verification
REQ-037 SHALL cover: acc_active=1, write 64'hDEAD_BEEF_0000_0001 to BASE+5, next cycle read BASE+5 -> bar_data_out=64'hDEAD_BEEF_0000_0001 one cycle later; wr_count=1.
REQ-038 SHALL cover: same-cycle write 64'h2 / read at BASE+7 holding 64'h1 -> bar_data_out=64'h1, then 64'h2 on the next cycle.
REQ-039 SHALL cover: host_req=1 read BASE+5 while acc_active=1 -> host_gnt=0; acc_active drops -> host_gnt=1 that cycle, host_rvalid=1 next cycle with host_rdata=64'hDEAD_BEEF_0000_0001.
REQ-040 SHALL cover: write to BASE+DEPTH -> memory unchanged, wr_count unchanged, err=1; err_clr=1 with a simultaneous out-of-range read -> err stays 1; err_clr alone -> err=0.
REQ-041 SHALL cover: rst=1 during a host read grant cycle -> host_rvalid=0 next cycle, all outputs 0; previously written BASE+5 still reads 64'hDEAD_BEEF_0000_0001.
REQ-042 SHALL cover: wr_count preloaded via 2^32-1 writes (or forced) -> further writes keep wr_count=32'hFFFF_FFFF.

Source files
------------

// File: rtl/bar_sram_if.sv
// Accelerator BAR port, host request port and status for the shared SRAM bank.
interface bar_sram_if #(
    parameter int WIDTH = 64
);
    logic             bar_write_en;
    logic [WIDTH-1:0] bar_data_in;
    logic [31:0]      bar_addr;
    logic [WIDTH-1:0] bar_data_out;
    logic             acc_active;
    logic             host_req;
    logic             host_we;
    logic [31:0]      host_addr;
    logic [WIDTH-1:0] host_wdata;
    logic             host_gnt;
    logic             host_rvalid;
    logic [WIDTH-1:0] host_rdata;
    logic             err;
    logic             err_clr;
    logic [31:0]      wr_count;

    modport master (
        output bar_write_en, bar_data_in, bar_addr, acc_active,
               host_req, host_we, host_addr, host_wdata, err_clr,
        input  bar_data_out, host_gnt, host_rvalid, host_rdata, err, wr_count
    );

    modport slave (
        input  bar_write_en, bar_data_in, bar_addr, acc_active,
               host_req, host_we, host_addr, host_wdata, err_clr,
        output bar_data_out, host_gnt, host_rvalid, host_rdata, err, wr_count
    );
endinterface

// File: rtl/bar_sram_responder.sv
// SRAM bank shared between an accelerator BAR port (while acc_active) and a host
// request port (otherwise). Read-first, registered reads, sticky range error.
module bar_sram_responder #(
    parameter int          WIDTH = 64,
    parameter int          DEPTH = 4096,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    bar_sram_if.slave  bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH32 = 32'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_bar_data_out;
    logic [WIDTH-1:0] r_host_rdata;
    logic             r_host_rvalid;
    logic             r_err;
    logic [31:0]      r_wr_count;

    logic [31:0]      w_bar_idx;
    logic [31:0]      w_host_idx;
    logic [31:0]      w_wr_idx;
    logic             w_bar_in;
    logic             w_host_in;
    logic             w_wr_in;
    logic             w_gnt;
    logic             w_host_rd;
    logic             w_wr;
    logic             w_wr_ok;
    logic             w_err_set;
    logic [WIDTH-1:0] w_wdata;

    always_comb begin
        w_bar_idx  = bus.bar_addr - BASE;
        w_host_idx = bus.host_addr - BASE;
        w_bar_in   = (w_bar_idx < DEPTH32);
        w_host_in  = (w_host_idx < DEPTH32);
        w_gnt      = bus.host_req & ~bus.acc_active;
        w_host_rd  = w_gnt & ~bus.host_we;
        // Ownership is exclusive, so the write port is a simple mux on acc_active.
        w_wr       = ~rst & ((bus.acc_active & bus.bar_write_en) | (w_gnt & bus.host_we));
        w_wr_idx   = bus.acc_active ? w_bar_idx : w_host_idx;
        w_wr_in    = bus.acc_active ? w_bar_in  : w_host_in;
        w_wdata    = bus.acc_active ? bus.bar_data_in : bus.host_wdata;
        w_wr_ok    = w_wr & w_wr_in;
        w_err_set  = (w_wr & ~w_wr_in)
                   | (bus.acc_active & ~w_bar_in)
                   | (w_host_rd & ~w_host_in);
    end

    // No reset on the array: contents survive rst and start undefined.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx[AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bar_data_out <= '0;
            r_host_rdata   <= '0;
            r_host_rvalid  <= 1'b0;
            r_err          <= 1'b0;
            r_wr_count     <= '0;
        end else begin
            r_bar_data_out <= w_bar_in ? r_mem[w_bar_idx[AW-1:0]] : '0;
            r_host_rvalid  <= w_host_rd;
            if (w_host_rd) begin
                r_host_rdata <= w_host_in ? r_mem[w_host_idx[AW-1:0]] : '0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
            if (w_wr_ok && (r_wr_count != 32'hFFFF_FFFF)) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign bus.host_gnt     = w_gnt;
    assign bus.bar_data_out = r_bar_data_out;
    assign bus.host_rdata   = r_host_rdata;
    assign bus.host_rvalid  = r_host_rvalid;
    assign bus.err          = r_err;
    assign bus.wr_count     = r_wr_count;
endmodule
